fifo_pack_sdp: RTL and testbench

FIFO_PACK_SDP -- requirements
Module: fifo_pack_sdp

---
 rtl/ram_pkg.sv | 24 ++
 rtl/ram_sdp.sv | 33 +++
 rtl/fifo_pack_sdp.sv | 163 ++++++++++++++++
 tb/tb_fifo_pack_sdp.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM helpers, parameter checks and default sizes
package ram_pkg;

  localparam int DEF_DIN_W = 8;
  localparam int DEF_RATIO = 2;
  localparam int DEF_DEPTH = 512;

  // Ceiling log2 with clog2(1) == 0, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit ratio_ok(input int v);
    return (v == 1) || (v == 2) || (v == 4) || (v == 8);
  endfunction

  function automatic bit depth_ok(input int v);
    return (v >= 16) && (v <= 4096) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// rtl/ram_sdp.sv - inferred simple dual-port RAM with a registered, enabled read port
module ram_sdp
  import ram_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 512
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]            wdata_i,
  input  logic                    re_i,
  input  logic [clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]            rdata_o
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_pack_sdp.sv
// rtl/fifo_pack_sdp.sv - narrow-to-wide packing FWFT FIFO; FIFO_PACK_OREG_EN adds a registered output stage
module fifo_pack_sdp
  import ram_pkg::*;
#(
  parameter int DIN_W = DEF_DIN_W,
  parameter int RATIO = DEF_RATIO,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [DIN_W-1:0]       din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [DIN_W*RATIO-1:0] dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [clog2(DEPTH):0]  level,
  output logic [clog2(RATIO):0]  pack_cnt
);

  localparam int WW = DIN_W * RATIO;
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = clog2(RATIO) + 1;

  if (!ratio_ok(RATIO) || !depth_ok(DEPTH)) begin : g_bad_param
    $error("fifo_pack_sdp: RATIO must be 1/2/4/8 and DEPTH a power of two in 16..4096");
  end

  logic          init_q;
  logic [CW-1:0] cnt_q;
  logic [WW-1:0] part_q;
  logic [WW-1:0] hold_q;
  logic          hold_vld_q;
  logic [WW-1:0] word_d;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wvis_q;
  logic [PW-1:0] rptr_q;
  logic          head_vld_q;

  logic [PW-1:0] mem_cnt;
  logic [PW-1:0] rptr_nxt;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic          full;
  logic          accept;
  logic          complete;
  logic          wr_en;
  logic          rd_en;
  logic          pop_head;

  assign mem_cnt   = wptr_q - rptr_q;
  assign full      = (mem_cnt == PW'(DEPTH));
  assign din_ready = init_q & ~(hold_vld_q & full);
  assign accept    = din_valid & din_ready;
  assign complete  = accept & (cnt_q == CW'(RATIO - 1));
  assign wr_en     = hold_vld_q & ~full;
  assign pack_cnt  = cnt_q;

  // Little-endian placement: beat n of a word lands in lane n.
  always_comb begin
    word_d = part_q;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) word_d[i*DIN_W +: DIN_W] = din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q     <= 1'b0;
      cnt_q      <= '0;
      part_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      wptr_q     <= '0;
      wvis_q     <= '0;
    end else if (clear) begin
      init_q     <= 1'b1;
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      wptr_q     <= '0;
      wvis_q     <= '0;
    end else begin
      init_q <= 1'b1;
      if (accept) begin
        part_q <= word_d;
        cnt_q  <= complete ? '0 : cnt_q + CW'(1);
      end
      if (complete) hold_q <= word_d;
      hold_vld_q <= complete | (hold_vld_q & ~wr_en);
      if (wr_en) wptr_q <= wptr_q + PW'(1);
      // Read side sees writes one edge late, so a fresh word never races its own write.
      wvis_q <= wptr_q;
    end
  end

  // The head word stays counted in memory until it leaves the read register.
  assign rptr_nxt = rptr_q + PW'(1);
  assign rd_en    = pop_head ? (rptr_nxt != wvis_q) : (~head_vld_q & (rptr_q != wvis_q));
  assign rd_addr  = pop_head ? rptr_nxt[AW-1:0] : rptr_q[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q     <= '0;
      head_vld_q <= 1'b0;
    end else if (clear) begin
      rptr_q     <= '0;
      head_vld_q <= 1'b0;
    end else if (pop_head) begin
      rptr_q     <= rptr_nxt;
      head_vld_q <= (rptr_nxt != wvis_q);
    end else if (rd_en) begin
      head_vld_q <= 1'b1;
    end
  end

  ram_sdp #(
    .W     (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_en),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (hold_q),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

`ifdef FIFO_PACK_OREG_EN
  logic [WW-1:0] oreg_q;
  logic          ovld_q;

  // Read register plus output register form the two-entry skid.
  assign pop_head = head_vld_q & (~ovld_q | dout_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oreg_q <= '0;
      ovld_q <= 1'b0;
    end else if (clear) begin
      ovld_q <= 1'b0;
    end else if (pop_head) begin
      oreg_q <= rd_data;
      ovld_q <= 1'b1;
    end else if (dout_ready) begin
      ovld_q <= 1'b0;
    end
  end

  assign dout       = oreg_q;
  assign dout_valid = ovld_q;
  assign level      = mem_cnt + PW'(ovld_q);
`else
  assign pop_head   = head_vld_q & dout_ready;
  assign dout       = rd_data;
  assign dout_valid = head_vld_q;
  assign level      = mem_cnt;
`endif

endmodule

// File: tb/tb_fifo_pack_sdp.sv
// tb/tb_fifo_pack_sdp.sv - scoreboard bench for fifo_pack_sdp in default, RATIO=4 and RATIO=1 builds
module tb_fifo_pack_sdp;

`ifdef FIFO_PACK_OREG_EN
  localparam int LAT   = 4;
  localparam int B_LVL = 17;
  localparam int B_ACC = 72;
`else
  localparam int LAT   = 3;
  localparam int B_LVL = 16;
  localparam int B_ACC = 68;
`endif

  logic clk;
  logic reset;

  logic        clear_a, din_valid_a, din_ready_a, dout_valid_a, dout_ready_a;
  logic [7:0]  din_a;
  logic [15:0] dout_a;
  logic [9:0]  level_a;
  logic [1:0]  pack_cnt_a;

  logic        clear_b, din_valid_b, din_ready_b, dout_valid_b, dout_ready_b;
  logic [7:0]  din_b;
  logic [31:0] dout_b;
  logic [4:0]  level_b;
  logic [2:0]  pack_cnt_b;

  logic        clear_c, din_valid_c, din_ready_c, dout_valid_c, dout_ready_c;
  logic [7:0]  din_c;
  logic [7:0]  dout_c;
  logic [4:0]  level_c;
  logic [0:0]  pack_cnt_c;

  fifo_pack_sdp u_a (
    .clk(clk), .reset(reset), .clear(clear_a),
    .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
    .level(level_a), .pack_cnt(pack_cnt_a)
  );

  fifo_pack_sdp #(.DIN_W(8), .RATIO(4), .DEPTH(16)) u_b (
    .clk(clk), .reset(reset), .clear(clear_b),
    .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b),
    .level(level_b), .pack_cnt(pack_cnt_b)
  );

  fifo_pack_sdp #(.DIN_W(8), .RATIO(1), .DEPTH(16)) u_c (
    .clk(clk), .reset(reset), .clear(clear_c),
    .din(din_c), .din_valid(din_valid_c), .din_ready(din_ready_c),
    .dout(dout_c), .dout_valid(dout_valid_c), .dout_ready(dout_ready_c),
    .level(level_c), .pack_cnt(pack_cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] qa[$];
  logic [15:0] pa_w = '0;
  int          pa_n = 0;
  int          pops_a = 0;
  int          cyc = 0;
  int          last_pop = -1;
  bit          stream_on = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!stream_on) last_pop = -1;
    if (reset) begin
      qa.delete();
      pa_n = 0;
      pa_w = '0;
    end else begin
      check("a_pcnt", 64'(pack_cnt_a), 64'(pa_n));
      if (clear_a) begin
        qa.delete();
        pa_n = 0;
        pa_w = '0;
      end else begin
        if (dout_valid_a && dout_ready_a) begin
          if (qa.size() == 0) check("a_spur", 64'(dout_valid_a), 64'd0);
          else check("a_dout", 64'(dout_a), 64'(qa.pop_front()));
          if (stream_on && last_pop >= 0) check("a_gap", 64'(cyc - last_pop), 64'd2);
          last_pop = cyc;
          pops_a++;
        end
        if (din_valid_a && din_ready_a) begin
          pa_w[pa_n*8 +: 8] = din_a;
          pa_n++;
          if (pa_n == 2) begin
            qa.push_back(pa_w);
            pa_n = 0;
            pa_w = '0;
          end
        end
      end
    end
  end

  logic [7:0] qc[$];
  int         pops_c = 0;
  int         push_c = 0;

  always @(negedge clk) begin
    if (reset) begin
      qc.delete();
    end else begin
      check("c_pcnt", 64'(pack_cnt_c), 64'd0);
      if (dout_valid_c && dout_ready_c) begin
        if (qc.size() == 0) check("c_spur", 64'(dout_valid_c), 64'd0);
        else check("c_dout", 64'(dout_c), 64'(qc.pop_front()));
        pops_c++;
      end
      if (din_valid_c && din_ready_c) begin
        qc.push_back(din_c);
        push_c++;
      end
    end
  end

  initial begin
    int p0;
    int acc;
    int rdrop;
    logic rdy;
    logic [7:0] v;

    reset = 1'b1;
    clear_a = 0; din_valid_a = 0; din_a = '0; dout_ready_a = 0;
    clear_b = 0; din_valid_b = 0; din_b = '0; dout_ready_b = 0;
    clear_c = 0; din_valid_c = 0; din_c = '0; dout_ready_c = 0;
    repeat (2) tick();

    check("rst_rdy", 64'(din_ready_a), 64'd0);
    check("rst_vld", 64'(dout_valid_a), 64'd0);
    check("rst_dout", 64'(dout_a), 64'd0);
    check("rst_lvl", 64'(level_a), 64'd0);
    check("rst_pcnt", 64'(pack_cnt_a), 64'd0);
    reset = 1'b0;
    check("rdy_pre", 64'(din_ready_a), 64'd0);
    tick();
    check("rdy_post", 64'(din_ready_a), 64'd1);

    // Two beats into an empty FIFO, exact first-word latency.
    din_valid_a = 1; din_a = 8'h11;
    tick();
    din_a = 8'h22;
    tick();
    din_valid_a = 0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) check("lat_early", 64'(dout_valid_a), 64'd0);
    end
    check("lat_vld", 64'(dout_valid_a), 64'd1);
    check("lat_dout", 64'(dout_a), 64'h2211);
    check("lat_lvl", 64'(level_a), 64'd1);
    tick();
    check("hold_dout", 64'(dout_a), 64'h2211);
    dout_ready_a = 1;
    tick();
    check("pop_vld", 64'(dout_valid_a), 64'd0);
    check("pop_lvl", 64'(level_a), 64'd0);

    // Clear with one stored word and one partial beat.
    dout_ready_a = 0;
    din_valid_a = 1; din_a = 8'h55; tick();
    din_a = 8'h66; tick();
    din_a = 8'hAA; tick();
    din_valid_a = 0;
    repeat (4) tick();
    check("clr_pre_pcnt", 64'(pack_cnt_a), 64'd1);
    check("clr_pre_lvl", 64'(level_a), 64'd1);
    clear_a = 1; din_valid_a = 1; din_a = 8'hEE;
    tick();
    clear_a = 0; din_valid_a = 0;
    check("clr_pcnt", 64'(pack_cnt_a), 64'd0);
    check("clr_lvl", 64'(level_a), 64'd0);
    check("clr_vld", 64'(dout_valid_a), 64'd0);
    p0 = pops_a;
    din_valid_a = 1; din_a = 8'h01; tick();
    din_a = 8'h02; tick();
    din_valid_a = 0; dout_ready_a = 1;
    repeat (8) tick();
    check("clr_pops", 64'(pops_a - p0), 64'd1);

    // Continuous stream of 2000 beats with pointer wrap.
    p0 = pops_a; rdrop = 0; acc = 0; v = 8'h00;
    stream_on = 1'b1; din_valid_a = 1;
    for (int c = 0; c < 2200 && acc < 2000; c++) begin
      din_a = v;
      rdy = din_ready_a;
      tick();
      if (rdy) begin v++; acc++; end
      else rdrop++;
    end
    din_valid_a = 0;
    repeat (12) tick();
    stream_on = 1'b0;
    check("strm_acc", 64'(acc), 64'd2000);
    check("strm_rdrop", 64'(rdrop), 64'd0);
    check("strm_pops", 64'(pops_a - p0), 64'd1000);
    check("strm_lvl", 64'(level_a), 64'd0);

    // Reset while a word is presented and a beat is partially packed.
    dout_ready_a = 0;
    din_valid_a = 1; din_a = 8'h77; tick();
    din_a = 8'h88; tick();
    din_a = 8'h99; tick();
    din_valid_a = 0;
    repeat (5) tick();
    check("mrst_pre_vld", 64'(dout_valid_a), 64'd1);
    reset = 1'b1;
    #1;
    check("mrst_rdy", 64'(din_ready_a), 64'd0);
    check("mrst_vld", 64'(dout_valid_a), 64'd0);
    check("mrst_dout", 64'(dout_a), 64'd0);
    check("mrst_lvl", 64'(level_a), 64'd0);
    check("mrst_pcnt", 64'(pack_cnt_a), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("mrst_rdy_up", 64'(din_ready_a), 64'd1);
    check("mrst_no_vld", 64'(dout_valid_a), 64'd0);
    p0 = pops_a;
    din_valid_a = 1; din_a = 8'h33; tick();
    din_a = 8'h44; tick();
    din_valid_a = 0; dout_ready_a = 1;
    repeat (8) tick();
    check("mrst_pops", 64'(pops_a - p0), 64'd1);
    check("mrst_lvl_end", 64'(level_a), 64'd0);

    // RATIO=4, DEPTH=16 fill with reads blocked.
    acc = 0;
    din_valid_b = 1;
    for (int c = 0; c < 150; c++) begin
      din_b = 8'(acc);
      rdy = din_ready_b;
      tick();
      if (rdy) acc++;
    end
    check("b_acc", 64'(acc), 64'(B_ACC));
    check("b_rdy_full", 64'(din_ready_b), 64'd0);
    check("b_lvl", 64'(level_b), 64'(B_LVL));
    check("b_pcnt", 64'(pack_cnt_b), 64'd0);
    check("b_vld", 64'(dout_valid_b), 64'd1);
    check("b_dout", 64'(dout_b), 64'h03020100);
    din_valid_b = 0; dout_ready_b = 1;
    tick();
    dout_ready_b = 0;
    check("b_rdy_free", 64'(din_ready_b), 64'd1);
    check("b_dout2", 64'(dout_b), 64'h07060504);

    // RATIO=1 passthrough with random handshakes.
    for (int c = 0; c < 80; c++) begin
      din_c = 8'($urandom);
      din_valid_c = 1'($urandom_range(0, 1));
      dout_ready_c = 1'($urandom_range(0, 1));
      tick();
    end
    din_valid_c = 0; dout_ready_c = 1;
    repeat (10) tick();
    check("c_count", 64'(pops_c), 64'(push_c));
    check("c_lvl", 64'(level_c), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
